// File: rtl/branch_resolve_unit.sv
// RV32I conditional branch resolver: drives an external comparator, registers the
// resolution for fetch over valid/ready, and keeps saturating perf counters.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  output logic [XLEN-1:0]  cmp_A,
  output logic [XLEN-1:0]  cmp_B,
  output logic             cmp_BrUn,
  input  logic             cmp_Eq,
  input  logic             cmp_Lt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic [2:0]       r_funct3;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_imm;
  logic             r_pred;
  logic [XLEN-1:0]  r_cmp_a;
  logic [XLEN-1:0]  r_cmp_b;
  logic             r_cmp_brun;
  logic             r_out_valid;
  logic             r_out_taken;
  logic [XLEN-1:0]  r_out_target;
  logic             r_out_mispredict;
  logic             r_out_illegal;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_mis_count;

  logic             w_illegal;
  logic             w_cond;
  logic             w_taken;
  logic [XLEN-1:0]  w_target;

  // 010 and 011 are the only unassigned BRANCH funct3 encodings.
  assign w_illegal = (r_funct3[2:1] == 2'b01);

  always_comb begin
    w_cond = 1'b0;
    case (r_funct3)
      3'b000:  w_cond = cmp_Eq;
      3'b001:  w_cond = ~cmp_Eq;
      3'b100:  w_cond = cmp_Lt;
      3'b101:  w_cond = ~cmp_Lt;
      3'b110:  w_cond = cmp_Lt;
      3'b111:  w_cond = ~cmp_Lt;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken  = w_cond & ~w_illegal;
  assign w_target = w_taken ? (r_pc + r_imm) : (r_pc + XLEN'(4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_funct3         <= '0;
      r_pc             <= '0;
      r_imm            <= '0;
      r_pred           <= 1'b0;
      r_cmp_a          <= '0;
      r_cmp_b          <= '0;
      r_cmp_brun       <= 1'b0;
      r_out_valid      <= 1'b0;
      r_out_taken      <= 1'b0;
      r_out_target     <= '0;
      r_out_mispredict <= 1'b0;
      r_out_illegal    <= 1'b0;
      r_br_count       <= '0;
      r_mis_count      <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_funct3   <= in_funct3;
            r_pc       <= in_pc;
            r_imm      <= in_imm;
            r_pred     <= in_pred_taken;
            r_cmp_a    <= in_rs1;
            r_cmp_b    <= in_rs2;
            r_cmp_brun <= in_funct3[1];
            r_state    <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          r_out_taken      <= w_taken;
          r_out_target     <= w_target;
          r_out_mispredict <= (w_taken != r_pred);
          r_out_illegal    <= w_illegal;
          r_out_valid      <= 1'b1;
          r_state          <= S_RESP;
        end
        S_RESP: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
            if (!r_out_illegal && (r_br_count != CNT_MAX))
              r_br_count <= r_br_count + CNT_W'(1);
            if (r_out_mispredict && (r_mis_count != CNT_MAX))
              r_mis_count <= r_mis_count + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready       = (r_state == S_IDLE);
  assign cmp_A          = r_cmp_a;
  assign cmp_B          = r_cmp_b;
  assign cmp_BrUn       = r_cmp_brun;
  assign out_valid      = r_out_valid;
  assign out_taken      = r_out_taken;
  assign out_target     = r_out_target;
  assign out_mispredict = r_out_mispredict;
  assign out_illegal    = r_out_illegal;
  assign br_count       = r_br_count;
  assign mis_count      = r_mis_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit with a behavioural comparator model;
// counters are 2 bits wide so saturation is reachable with a handful of branches.
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_rs1, in_rs2, in_pc, in_imm;
  logic             in_pred_taken;
  logic [XLEN-1:0]  cmp_A, cmp_B;
  logic             cmp_BrUn, cmp_Eq, cmp_Lt;
  logic             out_valid, out_ready, out_taken, out_mispredict, out_illegal;
  logic [XLEN-1:0]  out_target;
  logic [CNT_W-1:0] br_count, mis_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken),
    .cmp_A(cmp_A), .cmp_B(cmp_B), .cmp_BrUn(cmp_BrUn),
    .cmp_Eq(cmp_Eq), .cmp_Lt(cmp_Lt),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_target(out_target), .out_mispredict(out_mispredict),
    .out_illegal(out_illegal), .br_count(br_count), .mis_count(mis_count)
  );

  // External branch_comp: combinational on the registered operands.
  assign cmp_Eq = (cmp_A == cmp_B);
  assign cmp_Lt = cmp_BrUn ? (cmp_A < cmp_B) : ($signed(cmp_A) < $signed(cmp_B));

  typedef struct packed {
    logic             taken;
    logic [XLEN-1:0]  target;
    logic             mis;
    logic             ill;
    logic [CNT_W-1:0] br;
    logic [CNT_W-1:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops on each handshake, checks counters on the following negedge.
  exp_t mon_exp;
  logic cnt_pending = 1'b0;
  always @(negedge clk) begin
    if (cnt_pending) begin
      cnt_pending = 1'b0;
      check("br_count", XLEN'(br_count), XLEN'(mon_exp.br));
      check("mis_count", XLEN'(mis_count), XLEN'(mon_exp.mc));
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("taken", XLEN'(out_taken), XLEN'(mon_exp.taken));
        check("target", out_target, mon_exp.target);
        check("mispredict", XLEN'(out_mispredict), XLEN'(mon_exp.mis));
        check("illegal", XLEN'(out_illegal), XLEN'(mon_exp.ill));
        $display("RESP taken=%0b target=0x%08h mis=%0b ill=%0b", out_taken, out_target,
                 out_mispredict, out_illegal);
        cnt_pending = 1'b1;
      end
    end
  end

  task automatic drive_req(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    @(negedge clk);
    in_valid      = 1'b1;
    in_funct3     = f3;
    in_rs1        = rs1;
    in_rs2        = rs2;
    in_pc         = pc;
    in_imm        = imm;
    in_pred_taken = pred;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("cmp_A", cmp_A, rs1);
    check("cmp_B", cmp_B, rs2);
    check("cmp_BrUn", XLEN'(cmp_BrUn), XLEN'(f3[1]));
    check("lat_edge1_valid", XLEN'(out_valid), 32'd0);
    check("busy_ready", XLEN'(in_ready), 32'd0);
  endtask

  task automatic send(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                      input int hold, input exp_t e);
    logic [XLEN-1:0]  snap_target;
    logic             snap_taken;
    logic [CNT_W-1:0] snap_br, snap_mc;
    $display("REQ f3=%03b rs1=0x%08h rs2=0x%08h pc=0x%08h imm=0x%08h pred=%0b hold=%0d",
             f3, rs1, rs2, pc, imm, pred, hold);
    exp_q.push_back(e);
    out_ready = 1'b0;
    drive_req(f3, rs1, rs2, pc, imm, pred);
    @(posedge clk);
    #1;
    check("lat_edge2_valid", XLEN'(out_valid), 32'd1);
    snap_target = out_target;
    snap_taken  = out_taken;
    snap_br     = br_count;
    snap_mc     = mis_count;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", XLEN'(out_valid), 32'd1);
      check("bp_ready", XLEN'(in_ready), 32'd0);
      check("bp_target", out_target, snap_target);
      check("bp_taken", XLEN'(out_taken), XLEN'(snap_taken));
      check("bp_counts", XLEN'({snap_br, snap_mc}), XLEN'({br_count, mis_count}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_hs_valid", XLEN'(out_valid), 32'd0);
    check("post_hs_ready", XLEN'(in_ready), 32'd1);
  endtask

  // Abort a request with flush either in COMPARE (stage 0) or RESP (stage 1).
  task automatic flush_at(input int stage);
    logic [CNT_W-1:0] snap_br, snap_mc;
    $display("FLUSH stage=%0d", stage);
    snap_br = br_count;
    snap_mc = mis_count;
    out_ready = 1'b0;
    drive_req(3'b000, 32'h1, 32'h1, 32'h800, 32'h10, 1'b0);
    if (stage == 1) begin
      @(posedge clk);
      #1;
      check("flush_pre_valid", XLEN'(out_valid), 32'd1);
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_valid", XLEN'(out_valid), 32'd0);
    check("flush_ready", XLEN'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("flush_still_idle", XLEN'(in_ready), 32'd1);
    check("flush_counts", XLEN'({br_count, mis_count}), XLEN'({snap_br, snap_mc}));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_funct3 = '0;
    in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0; in_pred_taken = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_ready", XLEN'(in_ready), 32'd1);
    check("rst_valid", XLEN'(out_valid), 32'd0);
    check("rst_target", out_target, 32'd0);
    check("rst_cmpA", cmp_A, 32'd0);
    check("rst_counts", XLEN'({br_count, mis_count}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //   f3      rs1           rs2           pc            imm           pred hold  taken target      mis ill br mc
    send(3'b110, 32'hFFFFFFF9, 32'hFFFFFFF5, 32'h00000100, 32'h00000020, 1'b0, 0, '{1'b0, 32'h00000104, 1'b0, 1'b0, 2'd1, 2'd0});
    send(3'b101, 32'hFFFFFFF9, 32'hFFFFFFF5, 32'h00000100, 32'h00000020, 1'b0, 0, '{1'b1, 32'h00000120, 1'b1, 1'b0, 2'd2, 2'd1});
    send(3'b000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h00000004, 32'hFFFFFFF8, 1'b1, 0, '{1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 2'd3, 2'd1});
    send(3'b001, 32'h00000005, 32'h00000005, 32'h00000200, 32'h00000040, 1'b0, 5, '{1'b0, 32'h00000204, 1'b0, 1'b0, 2'd3, 2'd1});

    flush_at(0);
    flush_at(1);

    // flush in IDLE must block an accept
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'hABCD; in_rs2 = 32'h1234; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", XLEN'(in_ready), 32'd1);
    check("flush_idle_cmpA", cmp_A, 32'h1);

    // asynchronous reset while holding a response
    out_ready = 1'b0;
    drive_req(3'b001, 32'h7, 32'h8, 32'h900, 32'h10, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_valid", XLEN'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", XLEN'(out_valid), 32'd0);
    check("arst_taken", XLEN'(out_taken), 32'd0);
    check("arst_target", out_target, 32'd0);
    check("arst_cmpA", cmp_A, 32'd0);
    check("arst_ready", XLEN'(in_ready), 32'd1);
    check("arst_counts", XLEN'({br_count, mis_count}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(3'b010, 32'h00000001, 32'h00000002, 32'h00000300, 32'h00000010, 1'b1, 0, '{1'b0, 32'h00000304, 1'b1, 1'b1, 2'd0, 2'd1});
    send(3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000400, 32'h00000080, 1'b0, 0, '{1'b1, 32'h00000480, 1'b1, 1'b0, 2'd1, 2'd2});
    send(3'b110, 32'h00000001, 32'hFFFFFFFF, 32'h00000500, 32'hFFFFFF00, 1'b0, 0, '{1'b1, 32'h00000400, 1'b1, 1'b0, 2'd2, 2'd3});
    send(3'b111, 32'h00000001, 32'hFFFFFFFF, 32'h00000600, 32'h00000008, 1'b1, 0, '{1'b0, 32'h00000604, 1'b1, 1'b0, 2'd3, 2'd3});
    send(3'b011, 32'h00000003, 32'h00000003, 32'h00000700, 32'h00000040, 1'b0, 0, '{1'b0, 32'h00000704, 1'b0, 1'b1, 2'd3, 2'd3});

    repeat (3) @(posedge clk);
    check("scoreboard_drained", XLEN'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
